mc_mask_fifo: RTL and testbench
===============================

Name: mc_mask_fifo

Overview:
- Next-generation multicast controller for the PE array's global-buffer-to-PE delivery network.
- Each incoming word carries a tag. The block compares the tag with a programmed ID under a programmable don't-care mask, plus an all-ones broadcast tag.
- Matching words are queued in a parametrised FIFO and delivered with a full valid/ready handshake. Non-matching words are consumed and dropped, so the upstream bus never stalls.
- Sits between a bus segment and one PE (or PE cluster) input port.

Parameters:
- DATA_BITWIDTH, 8, payload width in bits.
- ID_BITWIDTH, 4, tag/ID/mask width in bits.
- FIFO_DEPTH, 4, number of queued words; power of two, >=2.
- CNT_BITWIDTH, 16, width of the delivered-word counter.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_data  in  DATA_BITWIDTH  upstream payload.
- i_tag  in  ID_BITWIDTH  destination tag of i_data.
- i_valid  in  1  upstream word valid.
- o_ready  out  1  block can accept a word this cycle.
- o_data  out  DATA_BITWIDTH  FIFO head payload.
- o_valid  out  1  FIFO head valid.
- i_ready  in  1  downstream can take o_data.
- i_id  in  ID_BITWIDTH  new ID, from the top-ctrl scan chain.
- i_id_mask  in  ID_BITWIDTH  new mask; bit=1 means don't-care.
- i_id_valid  in  1  load i_id/i_id_mask.
- o_cur_id  out  ID_BITWIDTH  current ID register.
- o_match_cnt  out  CNT_BITWIDTH  words delivered since reset; saturating.
- o_drop  out  1  one-cycle pulse when an accepted word did not match.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - id_reg=0 and mask_reg=0.
  - FIFO emptied; read and write pointers = 0.
  - o_valid=0, o_data=0, o_match_cnt=0, o_drop=0, o_ready=1 from the first cycle after reset.
  - Reset mid-transfer discards all queued words. No partial state survives.
- Accept: occurs when i_valid && o_ready. o_ready = !full, registered from occupancy. There is no same-cycle pop-to-push bypass, so a full FIFO deasserts o_ready even when i_ready=1.
- Match rule, evaluated against the registers as they stand this cycle:
  - match = (((i_tag ^ id_reg) & ~mask_reg) == 0) || (i_tag == all-ones).
  - Accepted and match: push {i_data} into the FIFO.
  - Accepted and no match: no push; o_drop=1 in the following cycle.
- Config update: on i_id_valid, id_reg and mask_reg update at the clock edge. A word accepted in the same cycle uses the old values. o_cur_id = id_reg.
- Output:
  - o_valid = !empty; o_data = head entry. When o_valid=0, o_data=0.
  - Pop occurs when o_valid && i_ready.
  - o_data and o_valid stay stable while o_valid=1 && i_ready=0.
- Latency: an accepted matching word appears on o_valid the cycle after acceptance (1-cycle latency) when the FIFO was empty.
- Simultaneous push and pop:
  - Occupancy unchanged; both pointers advance.
  - Legal at any occupancy except full, where push is blocked by o_ready=0.
- Pointers: log2(FIFO_DEPTH)+1 bits, wrapping naturally. full when the MSBs differ and the lower bits are equal; empty when the pointers are equal.
- o_match_cnt: increments by 1 per pop and saturates at all-ones; it does not wrap.
- i_valid with a don't-care i_tag is ignored while o_ready=0 (upstream must hold).

Decomposition:
- Shared package mc_pkg: BROADCAST_TAG (all-ones of ID_BITWIDTH) and the function tag_match(tag,id,mask).
- Sub-module mc_sync_fifo (DATA_BITWIDTH, FIFO_DEPTH): push/pop, full/empty, head data, synchronous reset.
- Top block holds the ID/mask registers, match logic, drop pulse and counter.

Test Plan:
- Reset, load i_id=4'h5 with mask=0, send tag 5 data 8'hA1 with i_ready=1 -> o_valid the next cycle with o_data=8'hA1; o_match_cnt=1; o_drop never asserted.
- id=4'h4, mask=4'h3; send tags 4,5,7,8 with data 1,2,3,4 -> data 1,2,3 delivered in order; tag 8 produces one o_drop pulse; o_match_cnt=3.
- Send tag 4'hF with id=4'h2, mask=0 -> word delivered (broadcast); no drop.
- Hold i_ready=0 and push 5 matching words with DEPTH=4 -> o_ready=0 after the 4th accept and the 5th is held upstream; o_data stays at word 1. Release i_ready -> words 1-5 delivered in order; o_ready returns the cycle after the first pop.
- i_id_valid (id 3→6) in the same cycle as an accepted tag-3 word -> that word delivered; a following tag-3 word dropped; a tag-6 word delivered.
- With 3 words queued, assert i_rst for one cycle -> o_valid=0, o_match_cnt=0, o_cur_id=0 next cycle; no stale word is ever delivered.
- Counter saturation with CNT_BITWIDTH=2 and 5 pops -> o_match_cnt sticks at 3.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared tag-matching definitions for the multicast mask FIFO.
package mc_pkg;

  // The largest tag width the matcher handles. Narrower tags are zero-extended
  // and compared only over their own bits.
  localparam int unsigned MAX_ID_BITWIDTH = 32;

  typedef logic [MAX_ID_BITWIDTH-1:0] id_word_t;

  // The broadcast tag is all-ones over whatever tag width is in use.
  localparam id_word_t BROADCAST_TAG = '1;

  // Ones over the low 'width' bits.
  function automatic id_word_t width_mask(input int unsigned width);
    return (width >= MAX_ID_BITWIDTH) ? '1
                                      : ((id_word_t'(1) << width) - id_word_t'(1));
  endfunction

  // A tag matches when every cared-about bit equals the ID, or when it is the
  // broadcast tag. A mask bit of 1 marks that bit as don't-care.
  function automatic logic tag_match(input id_word_t tag,
                                     input id_word_t id,
                                     input id_word_t mask,
                                     input int unsigned width);
    id_word_t valid_bits;
    valid_bits = width_mask(width);
    return (((tag ^ id) & ~mask & valid_bits) == '0) ||
           ((tag & valid_bits) == (BROADCAST_TAG & valid_bits));
  endfunction

endpackage

// File: rtl/mc_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and a zeroed head when empty.
module mc_sync_fifo #(
  parameter int DATA_BITWIDTH = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_BITWIDTH-1:0] wr_data,
  output logic [DATA_BITWIDTH-1:0] rd_data,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]              wr_ptr;
  logic [AW:0]              rd_ptr;
  logic [DATA_BITWIDTH-1:0] mem [FIFO_DEPTH];
  logic                     do_push;
  logic                     do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; both may advance in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointers define
    // which entries are live and the head is forced to zero when empty.
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mc_mask_fifo.sv
// Multicast filter: matches tags against a masked ID (or broadcast), queues
// matching words, drops the rest, and counts delivered words.
module mc_mask_fifo
  import mc_pkg::*;
#(
  parameter int DATA_BITWIDTH = 8,
  parameter int ID_BITWIDTH   = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_BITWIDTH  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DATA_BITWIDTH-1:0] i_data,
  input  logic [ID_BITWIDTH-1:0]   i_tag,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [DATA_BITWIDTH-1:0] o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  input  logic [ID_BITWIDTH-1:0]   i_id,
  input  logic [ID_BITWIDTH-1:0]   i_id_mask,
  input  logic                     i_id_valid,
  output logic [ID_BITWIDTH-1:0]   o_cur_id,
  output logic [CNT_BITWIDTH-1:0]  o_match_cnt,
  output logic                     o_drop
);

  logic [ID_BITWIDTH-1:0]  id_reg;
  logic [ID_BITWIDTH-1:0]  mask_reg;
  logic [CNT_BITWIDTH-1:0] cnt_reg;
  logic                    drop_reg;
  logic                    full;
  logic                    empty;
  logic                    accept;
  logic                    match;
  logic                    pop;

  // Matching uses the registers as they stand, so a same-cycle config load
  // only affects later words.
  assign match   = tag_match(id_word_t'(i_tag), id_word_t'(id_reg),
                             id_word_t'(mask_reg), ID_BITWIDTH);
  assign o_ready = !full;
  assign accept  = i_valid && o_ready;
  assign o_valid = !empty;
  assign pop     = o_valid && i_ready;

  assign o_cur_id    = id_reg;
  assign o_match_cnt = cnt_reg;
  assign o_drop      = drop_reg;

  mc_sync_fifo #(
    .DATA_BITWIDTH (DATA_BITWIDTH),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (accept && match),
    .pop     (pop),
    .wr_data (i_data),
    .rd_data (o_data),
    .full    (full),
    .empty   (empty)
  );

  // ID/mask configuration registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      id_reg   <= '0;
      mask_reg <= '0;
    end else if (i_id_valid) begin
      id_reg   <= i_id;
      mask_reg <= i_id_mask;
    end
  end

  // Drop pulse one cycle after a non-matching accept; saturating pop counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drop_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      drop_reg <= accept && !match;
      if (pop && (cnt_reg != '1)) cnt_reg <= cnt_reg + CNT_BITWIDTH'(1);
    end
  end

endmodule

// File: tb/tb_mc_mask_fifo.sv
// Bench for mc_mask_fifo: directed steps then random traffic, all checked
// against a queue-based reference model of the filter and FIFO.
module tb_mc_mask_fifo;

  localparam int DW    = 8;
  localparam int IW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          tb_rst = 1'b1;
  logic [DW-1:0] tb_data = '0;
  logic [IW-1:0] tb_tag = '0;
  logic          tb_valid = 1'b0;
  logic          tb_ready = 1'b0;
  logic [IW-1:0] tb_id = '0;
  logic [IW-1:0] tb_mask = '0;
  logic          tb_idv = 1'b0;

  logic          o_ready, o_valid, o_drop;
  logic [DW-1:0] o_data;
  logic [IW-1:0] o_cur_id;
  logic [15:0]   o_match_cnt;

  logic          s_ready, s_valid, s_drop;
  logic [DW-1:0] s_data;
  logic [IW-1:0] s_cur_id;
  logic [1:0]    s_match_cnt;

  always #5 clk = ~clk;

  mc_mask_fifo dut (
    .i_clk(clk), .i_rst(tb_rst), .i_data(tb_data), .i_tag(tb_tag),
    .i_valid(tb_valid), .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
    .i_ready(tb_ready), .i_id(tb_id), .i_id_mask(tb_mask), .i_id_valid(tb_idv),
    .o_cur_id(o_cur_id), .o_match_cnt(o_match_cnt), .o_drop(o_drop)
  );

  // Same stimulus, narrow counter, to exercise saturation.
  mc_mask_fifo #(.CNT_BITWIDTH(2)) dut_sat (
    .i_clk(clk), .i_rst(tb_rst), .i_data(tb_data), .i_tag(tb_tag),
    .i_valid(tb_valid), .o_ready(s_ready), .o_data(s_data), .o_valid(s_valid),
    .i_ready(tb_ready), .i_id(tb_id), .i_id_mask(tb_mask), .i_id_valid(tb_idv),
    .o_cur_id(s_cur_id), .o_match_cnt(s_match_cnt), .o_drop(s_drop)
  );

  // Reference model state.
  int      n_checks = 0;
  int      n_fail   = 0;
  byte unsigned q[$];
  int      m_id = 0, m_mask = 0, m_cnt = 0, m_cnt_sat = 0;
  bit      m_drop = 0;
  bit      last_accept = 0;
  int      drops_seen = 0;
  string   phase = "reset";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  // Bitwise reading of the match rule: each cared-about bit must agree,
  // or the tag is the all-ones broadcast.
  function automatic bit ref_match(input int tag, input int id, input int mask);
    if (tag == (1 << IW) - 1) return 1'b1;
    for (int b = 0; b < IW; b++)
      if (!mask[b] && (tag[b] != id[b])) return 1'b0;
    return 1'b1;
  endfunction

  // Advance one clock: model the edge, then compare every output.
  task automatic tick();
    bit acc, pp, m;
    acc = tb_valid && (q.size() < DEPTH);
    pp  = tb_ready && (q.size() > 0);
    m   = ref_match(int'(tb_tag), m_id, m_mask);
    @(posedge clk);
    last_accept = 0;
    if (tb_rst) begin
      q.delete();
      m_id = 0; m_mask = 0; m_cnt = 0; m_cnt_sat = 0; m_drop = 0;
    end else begin
      if (pp) begin
        void'(q.pop_front());
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_sat < 3) m_cnt_sat++;
      end
      if (acc && m) q.push_back(tb_data);
      m_drop = acc && !m;
      last_accept = acc;
      if (m_drop) drops_seen++;
      if (tb_idv) begin
        m_id = int'(tb_id);
        m_mask = int'(tb_mask);
      end
    end
    #1;
    check("valid", o_valid, q.size() != 0);
    check("data", o_data, (q.size() != 0) ? q[0] : 8'h00);
    check("ready", o_ready, q.size() < DEPTH);
    check("cur_id", o_cur_id, m_id);
    check("cnt", o_match_cnt, m_cnt);
    check("drop", o_drop, m_drop);
    check("cnt_sat", s_match_cnt, m_cnt_sat);
  endtask

  task automatic send(input int tag, input int data);
    tb_valid = 1'b1;
    tb_tag   = IW'(tag);
    tb_data  = DW'(data);
  endtask

  task automatic load_id(input int id, input int mask);
    tb_idv  = 1'b1;
    tb_id   = IW'(id);
    tb_mask = IW'(mask);
  endtask

  task automatic idle();
    tb_valid = 1'b0;
    tb_idv   = 1'b0;
    tb_rst   = 1'b0;
  endtask

  initial begin
    // Reset.
    tb_rst = 1'b1; tb_ready = 1'b1;
    tick(); tick();
    idle();

    // Exact match, single word.
    phase = "exact";
    load_id(5, 0); tick(); idle();
    send(5, 8'hA1); tick(); idle();
    check("first_word", o_data, 8'hA1);
    tick();
    check("first_cnt", o_match_cnt, 1);
    check("no_drop_yet", drops_seen, 0);

    // Masked match: low two bits don't-care.
    phase = "masked";
    load_id(4, 3); tick(); idle();
    send(4, 1); tick();
    send(5, 2); tick();
    send(7, 3); tick();
    send(8, 4); tick(); idle();
    tick(); tick(); tick();
    check("masked_cnt", o_match_cnt, 4);
    check("masked_drops", drops_seen, 1);

    // Broadcast tag passes any ID.
    phase = "bcast";
    load_id(2, 0); tick(); idle();
    send(15, 8'h3C); tick(); idle();
    check("bcast_data", o_data, 8'h3C);
    tick();
    check("bcast_drops", drops_seen, 1);

    // Back-pressure: fill to depth, hold the fifth word upstream.
    phase = "full";
    tb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(2, 8'h11 + i);
      tick();
    end
    check("full_ready", o_ready, 1'b0);
    check("full_head", o_data, 8'h11);
    tick(); tick();
    tb_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_accept) break;
    end
    check("fifth_taken", last_accept, 1'b1);
    idle();
    for (int i = 0; i < 6; i++) tick();

    // Config update in the same cycle as an accepted word.
    phase = "cfg";
    load_id(3, 0); tick(); idle();
    load_id(6, 0); send(3, 8'h31); tick(); idle();
    send(3, 8'h32); tick();
    send(6, 8'h33); tick(); idle();
    tick(); tick();
    check("cfg_drops", drops_seen, 2);

    // Reset with words queued.
    phase = "midreset";
    tb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(6, 8'h60 + i);
      tick();
    end
    idle();
    tb_rst = 1'b1; tick(); tb_rst = 1'b0;
    check("rst_valid", o_valid, 1'b0);
    check("rst_id", o_cur_id, 0);
    tb_ready = 1'b1;
    tick(); tick();

    // Random traffic.
    phase = "random";
    for (int i = 0; i < 600; i++) begin
      tb_rst   = ($urandom_range(0, 99) == 0);
      tb_valid = ($urandom_range(0, 2) != 0);
      tb_tag   = IW'($urandom);
      tb_data  = DW'($urandom);
      tb_ready = ($urandom_range(0, 3) != 0);
      tb_idv   = ($urandom_range(0, 15) == 0);
      tb_id    = IW'($urandom);
      tb_mask  = IW'($urandom);
      tick();
    end
    idle();
    tb_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
